// File: rtl/debug_frame_tx_pkg.sv
// debug_frame_tx_pkg: shared debug-unit constants, FSM encoding and host command codes
package debug_frame_tx_pkg;
  localparam logic [7:0] DBG_HEADER = 8'hA5;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, FINISH} state_t;
  typedef enum logic [7:0] {
    CMD_START      = 8'h53,
    CMD_CONTINUOUS = 8'h43,
    CMD_STEP_MODE  = 8'h50,
    CMD_RESET_MIPS = 8'h52,
    CMD_ERASE_MEM  = 8'h45,
    CMD_STEP       = 8'h4E
  } host_cmd_t;
  function automatic int frame_len(input int n_words, input int len, input int len_data);
    return 2 + n_words * len / len_data;
  endfunction
endpackage

// File: rtl/debug_frame_tx_if.sv
// debug_frame_tx_if: command-side request, snapshot and UART TX handshake of the frame transmitter
interface debug_frame_tx_if #(
  parameter int N_WORDS = 36,
  parameter int LEN = 32,
  parameter int LEN_DATA = 8
);
  logic start;
  logic [N_WORDS*LEN-1:0] snapshot;
  logic tx_done;
  logic tx_start;
  logic [LEN_DATA-1:0] uart_data_out;
  logic busy;
  logic done;
  modport master (output start, snapshot, tx_done, input tx_start, uart_data_out, busy, done);
  modport slave (input start, snapshot, tx_done, output tx_start, uart_data_out, busy, done);
endinterface

// File: rtl/snapshot_byte_mux.sv
// snapshot_byte_mux: picks one byte of the shadow snapshot, byte 0 being the LSB of word 0
module snapshot_byte_mux #(
  parameter int W = 1152,
  parameter int LEN_DATA = 8,
  parameter int IW = 8
) (
  input logic [W-1:0] shadow,
  input logic [IW-1:0] sel,
  output logic [LEN_DATA-1:0] byte_out
);
  assign byte_out = LEN_DATA'(shadow >> (sel * LEN_DATA));
endmodule

// File: rtl/debug_frame_tx.sv
// debug_frame_tx: streams a captured snapshot as header, data bytes LSB-first and XOR checksum
module debug_frame_tx
  import debug_frame_tx_pkg::*;
#(
  parameter int LEN = 32,
  parameter int N_WORDS = 36,
  parameter int LEN_DATA = 8,
  parameter logic [LEN_DATA-1:0] HEADER = LEN_DATA'(DBG_HEADER)
) (
  input logic clk,
  input logic reset,
  debug_frame_tx_if.slave bus
);
  localparam int FRAME = frame_len(N_WORDS, LEN, LEN_DATA);
  localparam int IW = $clog2(FRAME);
  localparam logic [IW-1:0] LAST = IW'(FRAME - 1);
  state_t state, state_n;
  logic [N_WORDS*LEN-1:0] shadow;
  logic [IW-1:0] idx, idx_n;
  logic [LEN_DATA-1:0] chk, chk_n, data_n, mux_byte, sel_byte;
  logic cap, tx_start_n, done_n;
  snapshot_byte_mux #(.W(N_WORDS*LEN), .LEN_DATA(LEN_DATA), .IW(IW)) u_mux (
    .shadow(shadow),
    .sel(idx - IW'(1)),
    .byte_out(mux_byte)
  );
  assign sel_byte = (idx == '0) ? HEADER : (idx == LAST) ? chk : mux_byte;
  // next state, counter, checksum and output values; tx_done in the tx_start cycle is ignored
  always_comb begin
    state_n = state;
    idx_n = idx;
    chk_n = chk;
    data_n = bus.uart_data_out;
    tx_start_n = 1'b0;
    done_n = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        cap = 1'b1;
        idx_n = '0;
        chk_n = '0;
        state_n = LOAD;
      end
      LOAD: state_n = SEND;
      SEND: begin
        data_n = sel_byte;
        tx_start_n = 1'b1;
        state_n = WAIT;
      end
      WAIT: if (bus.tx_done && !bus.tx_start) begin
        chk_n = (idx != '0 && idx != LAST) ? chk ^ bus.uart_data_out : chk;
        done_n = (idx == LAST);
        state_n = (idx == LAST) ? FINISH : SEND;
        idx_n = (idx == LAST) ? idx : idx + IW'(1);
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // shadow copy isolates the frame in flight from later snapshot changes
  always_ff @(posedge clk or negedge reset)
    if (!reset) shadow <= '0;
    else if (cap) shadow <= bus.snapshot;
  // state, counter, checksum and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      chk <= '0;
      bus.tx_start <= 1'b0;
      bus.uart_data_out <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      chk <= chk_n;
      bus.tx_start <= tx_start_n;
      bus.uart_data_out <= data_n;
      bus.busy <= (state_n != IDLE);
      bus.done <= done_n;
    end
  end
endmodule

// File: tb/tb_debug_frame_tx.sv
// tb_debug_frame_tx: directed frame checks on a 2-word instance plus a default-size random frame
module tb_debug_frame_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debug_frame_tx_if #(.N_WORDS(2), .LEN(32), .LEN_DATA(8)) a ();
  debug_frame_tx_if b ();

  debug_frame_tx #(.LEN(32), .N_WORDS(2), .LEN_DATA(8), .HEADER(8'hA5)) u_a (.clk(clk), .reset(reset), .bus(a));
  debug_frame_tx u_b (.clk(clk), .reset(reset), .bus(b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q_a[$];
  int lat_a = 10;
  int cnt_a = 0;
  int done_a = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  int busy_fall = 0;
  int last_done = -1;
  logic prev_busy = 1'b0;
  logic pend_a = 1'b0;
  logic [7:0] cur_a = '0;
  logic stable_ok = 1'b1;
  logic gap_ok = 1'b1;

  logic [7:0] q_b[$];
  int cnt_b = 0;
  int done_b = 0;

  // UART TX model and monitor for the 2-word instance
  always @(negedge clk) begin
    cyc++;
    a.tx_done = 1'b0;
    if (!reset) begin
      cnt_a = 0;
      pend_a = 1'b0;
    end
    if (pend_a && a.uart_data_out !== cur_a) stable_ok = 1'b0;
    if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0) begin
        a.tx_done = 1'b1;
        pend_a = 1'b0;
        last_done = cyc;
      end
    end
    if (a.tx_start === 1'b1) begin
      q_a.push_back(a.uart_data_out);
      cur_a = a.uart_data_out;
      pend_a = 1'b1;
      if (last_done >= 0 && cyc - last_done != 2) gap_ok = 1'b0;
      cnt_a = lat_a;
    end
    if (a.done === 1'b1) begin
      done_a++;
      done_cyc = cyc;
    end
    if (prev_busy && a.busy !== 1'b1) begin
      busy_fall++;
      fall_cyc = cyc;
    end
    prev_busy = (a.busy === 1'b1);
  end

  // UART TX model for the default instance, tx_done one cycle after each tx_start
  always @(negedge clk) begin
    b.tx_done = 1'b0;
    if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) b.tx_done = 1'b1;
    end
    if (b.tx_start === 1'b1) begin
      q_b.push_back(b.uart_data_out);
      cnt_b = 1;
    end
    if (b.done === 1'b1) done_b++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_a();
    logic [127:0] r = '0;
    foreach (q_a[i]) r = {r[119:0], q_a[i]};
    return r;
  endfunction

  task automatic start_a(input logic [63:0] s);
    a.snapshot = s;
    q_a.delete();
    done_a = 0;
    busy_fall = 0;
    last_done = -1;
    stable_ok = 1'b1;
    gap_ok = 1'b1;
    a.start = 1'b1;
    @(posedge clk);
    #1 a.start = 1'b0;
  endtask

  task automatic wait_q_a(input int n);
    for (int i = 0; i < 400 && q_a.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    check("wait_bytes", 128'(q_a.size() >= n), 128'(1));
  endtask

  task automatic wait_done_a(input int n);
    for (int i = 0; i < 400 && done_a < n; i++) begin
      @(negedge clk);
      #1;
    end
    check("wait_done", 128'(done_a >= n), 128'(1));
    repeat (3) @(negedge clk);
    #1;
  endtask

  localparam logic [63:0] S1 = {32'h89ABCDEF, 32'h01234567};
  localparam logic [127:0] F1 = 128'hA5674523_01EFCDAB_8900;
  localparam logic [127:0] F2 = 128'hA5FF0000_00000000_00FF;
  localparam logic [127:0] F4 = 128'hA5443322_11EFBEAD_DE66;

  logic [36*32-1:0] big;
  logic [7:0] ref_chk;
  int mism;

  initial begin
    reset = 1'b0;
    a.start = 1'b0;
    a.snapshot = '0;
    b.start = 1'b0;
    b.snapshot = '0;
    #12;
    check("rst_tx_start", 128'(a.tx_start), 128'(0));
    check("rst_data", 128'(a.uart_data_out), 128'(0));
    check("rst_busy", 128'(a.busy), 128'(0));
    check("rst_done", 128'(a.done), 128'(0));
    check("rst_b_busy", 128'(b.busy), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    lat_a = 10;
    start_a(S1);
    check("f1_busy_edge0", 128'(a.busy), 128'(1));
    check("f1_txs_edge0", 128'(a.tx_start), 128'(0));
    @(posedge clk);
    #1 check("f1_txs_edge1", 128'(a.tx_start), 128'(0));
    @(posedge clk);
    #1 check("f1_txs_edge2", 128'(a.tx_start), 128'(1));
    check("f1_hdr_edge2", 128'(a.uart_data_out), 128'(8'hA5));
    wait_done_a(1);
    check("f1_len", 128'(q_a.size()), 128'(10));
    check("f1_bytes", pack_a(), F1);
    check("f1_done_cnt", 128'(done_a), 128'(1));
    check("f1_busy_after_done", 128'(fall_cyc - done_cyc), 128'(1));
    check("f1_stable", 128'(stable_ok), 128'(1));
    check("f1_gap", 128'(gap_ok), 128'(1));

    start_a({32'h00000000, 32'h000000FF});
    wait_done_a(1);
    check("f2_bytes", pack_a(), F2);
    check("f2_done_cnt", 128'(done_a), 128'(1));

    start_a(S1);
    wait_q_a(4);
    a.snapshot = '1;
    a.start = 1'b1;
    @(posedge clk);
    #1 a.start = 1'b0;
    wait_done_a(1);
    repeat (40) @(negedge clk);
    #1;
    check("f3_bytes", pack_a(), F1);
    check("f3_len", 128'(q_a.size()), 128'(10));
    check("f3_done_cnt", 128'(done_a), 128'(1));
    check("f3_busy_falls", 128'(busy_fall), 128'(1));

    lat_a = 1;
    start_a({32'hDEADBEEF, 32'h11223344});
    wait_done_a(1);
    check("f4_bytes", pack_a(), F4);
    check("f4_gap", 128'(gap_ok), 128'(1));
    check("f4_stable", 128'(stable_ok), 128'(1));

    lat_a = 10;
    start_a(S1);
    wait_q_a(6);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rm_tx_start", 128'(a.tx_start), 128'(0));
    check("rm_data", 128'(a.uart_data_out), 128'(0));
    check("rm_busy", 128'(a.busy), 128'(0));
    check("rm_done", 128'(a.done), 128'(0));
    repeat (20) @(negedge clk);
    check("rm_no_done", 128'(done_a), 128'(0));
    reset = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("rm_no_done_after", 128'(done_a), 128'(0));
    check("rm_idle_bytes", 128'(q_a.size()), 128'(6));
    start_a(S1);
    wait_done_a(1);
    check("rm_restart_bytes", pack_a(), F1);
    check("rm_restart_done", 128'(done_a), 128'(1));

    for (int i = 0; i < 36; i++) big[i*32 +: 32] = $urandom();
    ref_chk = '0;
    for (int j = 0; j < 144; j++) ref_chk ^= big[j*8 +: 8];
    b.snapshot = big;
    b.start = 1'b1;
    @(posedge clk);
    #1 b.start = 1'b0;
    b.snapshot = '0;
    for (int i = 0; i < 1000 && done_b < 1; i++) begin
      @(negedge clk);
      #1;
    end
    check("def_done", 128'(done_b), 128'(1));
    check("def_len", 128'(q_b.size()), 128'(146));
    mism = 0;
    if (q_b.size() >= 146) begin
      for (int j = 0; j < 144; j++) if (q_b[j+1] !== big[j*8 +: 8]) mism++;
      check("def_hdr", 128'(q_b[0]), 128'(8'hA5));
      check("def_chk", 128'(q_b[145]), 128'(ref_chk));
    end
    check("def_data_mism", 128'(mism), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
